// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_BUS       = 32;  // register data width
    localparam int unsigned REG_NUM_LOG2  = 5;   // register address width
    localparam int unsigned WB_FIFO_DEPTH = 2;   // secondary buffer entries
    localparam int unsigned WB_STARVE_MAX = 4;   // primary-won cycles before stall_req

    // Which source drives the regfile write port on a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,   // nothing to write
        SRC_PRI  = 2'd1,   // primary pipeline writeback
        SRC_SEC  = 2'd2,   // live FIFO head
        SRC_DEAD = 2'd3    // squashed FIFO head popped, no write
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Secondary writeback buffer: ordered entries with live bits, squash and forwarding lookup.
module regfile_wb_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              squash,
    input  logic [ADDR_W-1:0] squash_addr,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              head_live,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic [DEPTH-1:0]  live_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  fwd_idx;

    assign head_live = live_q[head_q];
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;

    // Storage, pointers and occupancy; squash only affects entries already held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[PTR_W'(i)] <= '0;
                data_q[PTR_W'(i)] <= '0;
            end
        end else begin
            if (squash) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (live_q[PTR_W'(i)] && (addr_q[PTR_W'(i)] == squash_addr)) begin
                        live_q[PTR_W'(i)] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end
            if (push) begin
                live_q[tail_q] <= 1'b1;
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest live match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && live_q[fwd_idx] &&
                (addr_q[fwd_idx] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback and buffered multi-cycle writeback onto the regfile write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = REG_BUS,
    parameter int unsigned ADDR_W     = REG_NUM_LOG2,
    parameter int unsigned DEPTH      = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_waddr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_waddr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              stall_req,
    output logic              busy
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic                p_we_eff;
    logic                push;
    logic                pop;
    logic                head_live;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [CNT_W-1:0]    fifo_count;
    wb_src_e             src;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_nxt;

    // Address 0 is hardwired; writes to it are dropped at the front door.
    assign p_we_eff = p_we && (p_waddr != '0);
    assign s_ready  = (fifo_count != CNT_W'(DEPTH));
    assign busy     = (fifo_count != '0);
    assign push     = s_valid && s_ready && (s_waddr != '0);
    assign pop      = !p_we_eff && busy;

    regfile_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (s_waddr),
        .push_data   (s_wdata),
        .pop         (pop),
        .squash      (p_we_eff),
        .squash_addr (p_waddr),
        .fwd_addr    (fwd_addr),
        .head_live   (head_live),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (fifo_count),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    // Source select and next starvation count.
    always_comb begin
        src        = SRC_NONE;
        starve_nxt = starve_q;
        if (p_we_eff) begin
            src = SRC_PRI;
        end else if (pop) begin
            src = head_live ? SRC_SEC : SRC_DEAD;
        end
        if (p_we_eff && busy && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_nxt = starve_q + STARVE_W'(1);
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            case (src)
                SRC_PRI: begin
                    we    <= 1'b1;
                    waddr <= p_waddr;
                    wdata <= p_wdata;
                end
                SRC_SEC: begin
                    we    <= 1'b1;
                    waddr <= head_addr;
                    wdata <= head_data;
                end
                default: begin
                    we    <= 1'b0;
                    waddr <= '0;
                    wdata <= '0;
                end
            endcase
        end
    end

    // Starvation tracking: any pop clears the count and releases the stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q  <= '0;
            stall_req <= 1'b0;
        end else if (pop) begin
            starve_q  <= '0;
            stall_req <= 1'b0;
        end else begin
            starve_q <= starve_nxt;
            if (starve_nxt == STARVE_W'(STARVE_MAX)) begin
                stall_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p_we = 1'b0;
    logic [AW-1:0] p_waddr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] s_waddr = '0;
    logic [DW-1:0] s_wdata = '0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] fwd_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          stall_req;
    logic          busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p_we      (p_we),
        .p_waddr   (p_waddr),
        .p_wdata   (p_wdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_waddr   (s_waddr),
        .s_wdata   (s_wdata),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .stall_req (stall_req),
        .busy      (busy)
    );

    // Model: pending secondary writes in arrival order, plus what the write port shows.
    typedef struct {
        bit            live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          m_stall;
    int            m_starve;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_stall  = 1'b0;
        m_starve = 0;
    endtask

    // Youngest live pending write to address a.
    task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].live && q[i].addr == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endtask

    // Apply one clock edge worth of behaviour to the model.
    task automatic model_step();
        logic pe;
        logic nonempty;
        logic room;
        ent_t e;
        pe       = p_we && (p_waddr != '0);
        nonempty = (q.size() != 0);
        room     = (q.size() < DEPTH);
        if (pe) begin
            foreach (q[i]) if (q[i].addr == p_waddr) q[i].live = 1'b0;
            m_we = 1'b1; m_waddr = p_waddr; m_wdata = p_wdata;
        end else if (nonempty) begin
            e = q.pop_front();
            m_we    = e.live;
            m_waddr = e.live ? e.addr : '0;
            m_wdata = e.live ? e.data : '0;
        end else begin
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end
        if (s_valid && room && (s_waddr != '0)) begin
            e.live = 1'b1; e.addr = s_waddr; e.data = s_wdata;
            q.push_back(e);
        end
        if (!pe && nonempty) begin
            m_starve = 0;
            m_stall  = 1'b0;
        end else if (pe && nonempty) begin
            if (m_starve < SMAX) m_starve++;
            if (m_starve == SMAX) m_stall = 1'b1;
        end
    endtask

    task automatic check_all();
        logic          h;
        logic [DW-1:0] d;
        model_fwd(fwd_addr, h, d);
        chk("we", 32'(we), 32'(m_we));
        chk("waddr", 32'(waddr), 32'(m_waddr));
        chk("wdata", wdata, m_wdata);
        chk("stall_req", 32'(stall_req), 32'(m_stall));
        chk("s_ready", 32'(s_ready), 32'(q.size() != DEPTH));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("fwd_hit", 32'(fwd_hit), 32'(h));
        chk("fwd_data", fwd_data, d);
    endtask

    // Drive one cycle at the falling edge, check, then advance the model at the rising edge.
    task automatic cyc(input logic pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic [AW-1:0] fa);
        p_we = pwe; p_waddr = pa; p_wdata = pd;
        s_valid = sv; s_waddr = sa; s_wdata = sd;
        fwd_addr = fa;
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    int unsigned pwe_pct;

    initial begin
        model_reset();
        #1;
        check_all();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Primary only
        cyc(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, '0);
        chk("t1_we", 32'(we), 32'd1);
        chk("t1_waddr", 32'(waddr), 32'd3);
        chk("t1_wdata", wdata, 32'h11);
        chk("t1_busy", 32'(busy), 32'd0);
        idle();

        // Secondary through an idle port
        cyc(1'b0, '0, '0, 1'b1, 5'd5, 32'hAA, '0);
        chk("t2_we_early", 32'(we), 32'd0);
        idle();
        chk("t2_we", 32'(we), 32'd1);
        chk("t2_waddr", 32'(waddr), 32'd5);
        chk("t2_wdata", wdata, 32'hAA);
        idle();

        // Squash of two buffered writes by a younger primary
        cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd5, 32'hAA, 5'd5);
        cyc(1'b1, 5'd9, 32'h98, 1'b1, 5'd5, 32'hBB, 5'd5);
        chk("t3_pre_hit", 32'(fwd_hit), 32'd1);
        chk("t3_pre_data", fwd_data, 32'hBB);
        cyc(1'b1, 5'd5, 32'hCC, 1'b0, '0, '0, 5'd5);
        chk("t3_hit", 32'(fwd_hit), 32'd0);
        chk("t3_wdata", wdata, 32'hCC);
        idle();
        chk("t3_dead0", 32'(we), 32'd0);
        idle();
        chk("t3_dead1", 32'(we), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);

        // Address zero writes vanish
        cyc(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, '0);
        chk("t0_we", 32'(we), 32'd0);
        chk("t0_busy", 32'(busy), 32'd0);

        // Full FIFO and starvation
        cyc(1'b1, 5'd9, 32'h1, 1'b1, 5'd6, 32'hD1, '0);
        cyc(1'b1, 5'd9, 32'h2, 1'b1, 5'd6, 32'hD2, '0);
        chk("t4_ready", 32'(s_ready), 32'd0);
        cyc(1'b1, 5'd10, 32'h3, 1'b1, 5'd6, 32'hD3, '0);
        chk("t4_stall2", 32'(stall_req), 32'd0);
        cyc(1'b1, 5'd11, 32'h4, 1'b0, '0, '0, '0);
        chk("t4_stall3", 32'(stall_req), 32'd0);
        cyc(1'b1, 5'd12, 32'h5, 1'b0, '0, '0, '0);
        chk("t4_stall4", 32'(stall_req), 32'd1);
        chk("t4_waddr", 32'(waddr), 32'd12);
        cyc(1'b1, 5'd13, 32'h6, 1'b0, '0, '0, '0);
        chk("t4_stall_hold", 32'(stall_req), 32'd1);
        idle();
        chk("t4_release", 32'(stall_req), 32'd0);
        chk("t4_pop_addr", 32'(waddr), 32'd6);
        chk("t4_pop_data", wdata, 32'hD1);
        idle();
        chk("t4_pop2_data", wdata, 32'hD2);
        chk("t4_empty", 32'(busy), 32'd0);
        idle();

        // Youngest match wins on forwarding
        cyc(1'b1, 5'd9, 32'h7, 1'b1, 5'd7, 32'h1, '0);
        cyc(1'b1, 5'd9, 32'h8, 1'b1, 5'd7, 32'h2, '0);
        cyc(1'b1, 5'd9, 32'h9, 1'b0, '0, '0, 5'd7);
        chk("t5_hit", 32'(fwd_hit), 32'd1);
        chk("t5_data", fwd_data, 32'h2);
        fwd_addr = '0;
        #1;
        chk("t5_zero_hit", 32'(fwd_hit), 32'd0);
        chk("t5_zero_data", fwd_data, 32'h0);

        // Asynchronous reset with a full FIFO
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_we", 32'(we), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(s_ready), 32'd1);
        chk("t6_stall", 32'(stall_req), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic; a second phase leans on the primary to provoke stalls
        for (int n = 0; n < 3000; n++) begin
            pwe_pct = (n < 1500) ? 50 : 85;
            if (n == 2200) begin
                rst = 1'b0;
                model_reset();
                #1 check_all();
                @(negedge clk);
                rst = 1'b1;
            end
            cyc(($urandom_range(0, 99) < pwe_pct), AW'($urandom_range(0, 7)), $urandom(),
                ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom(),
                AW'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
